// File: rtl/abp_pkg.sv
// Shared Alternating Bit Protocol definitions: frame layout constants,
// sender transmitter state encoding and the frame byte selector.
package abp_pkg;

    localparam int unsigned ABP_VALUE_BYTES  = 8;
    localparam int unsigned ABP_FRAME_BYTES  = 9;
    localparam int unsigned ABP_SEQ_BYTE_IDX = 8;

    typedef enum logic [1:0] {
        RESET_STATE,
        IDLE,
        SEND,
        WAIT_ACK
    } abp_tx_state_e;

    // Bytes 0..7 are the value little-endian; byte 8 carries the alternating bit.
    function automatic logic [7:0] abp_frame_byte(
        input logic [8*ABP_VALUE_BYTES-1:0] value,
        input logic                         seq,
        input logic [3:0]                   idx
    );
        if (idx == 4'(ABP_SEQ_BYTE_IDX)) begin
            return {7'b0, seq};
        end
        return value[{idx[2:0], 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/abp_retry_timer.sv
// Acknowledge wait timer: cleared on load, counts while enabled, flags the
// last cycle of the timeout window.
module abp_retry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/abp_sender_transmitter.sv
// ABP sender: serialises a 64-bit value plus sequence byte onto AXI-Stream,
// waits for the matching acknowledge and retransmits on timeout.
module abp_sender_transmitter
    import abp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        send_valid,
    output logic        send_ready,
    input  logic [63:0] send_value,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    input  logic        ack_valid,
    input  logic        ack_bit,
    output logic        seq_bit,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [7:0]  retry_count
);

    localparam logic [3:0] LAST_IDX = 4'(ABP_FRAME_BYTES - 1);

    abp_tx_state_e state_q, state_d;
    logic [63:0]   value_q, value_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    retry_q, retry_d;
    logic          seq_q, seq_d;
    logic          ready_q, ready_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic          timer_clear;
    logic          timer_en;
    logic          timer_expired;

    abp_retry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    // Outputs are computed for the cycle after the edge, so every port is a flop.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        seq_d       = seq_q;
        ready_d     = ready_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            RESET_STATE: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (send_valid && ready_q) begin
                    state_d  = SEND;
                    value_d  = send_value;
                    idx_d    = '0;
                    retry_d  = '0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = send_value[7:0];
                end else begin
                    ready_d = 1'b1;
                end
            end
            SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = WAIT_ACK;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        timer_clear = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        tdata_d = abp_frame_byte(value_q, seq_q, idx_q + 4'd1);
                        tlast_d = ((idx_q + 4'd1) == LAST_IDX);
                    end
                end
            end
            WAIT_ACK: begin
                timer_en = 1'b1;
                if (ack_valid && (ack_bit == seq_q)) begin
                    state_d = IDLE;
                    seq_d   = ~seq_q;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (timer_expired) begin
                    if (retry_q < 8'(MAX_RETRIES)) begin
                        state_d  = SEND;
                        retry_d  = retry_q + 8'd1;
                        idx_d    = '0;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tdata_d  = value_q[7:0];
                    end else begin
                        state_d = IDLE;
                        fail_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= RESET_STATE;
            value_q  <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            seq_q    <= 1'b0;
            ready_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            seq_q    <= seq_d;
            ready_q  <= ready_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    assign send_ready    = ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign seq_bit       = seq_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fail          = fail_q;
    assign retry_count   = retry_q;

endmodule

// File: tb/tb_abp_sender_transmitter.sv
// Directed bench for abp_sender_transmitter: frame layout, stalls, ack
// matching, timeout retransmission, retry exhaustion and mid-frame reset.
module tb_abp_sender_transmitter;

    localparam int unsigned TO = 20;
    localparam int unsigned MR = 2;

    logic        aclk;
    logic        aresetn;
    logic        send_valid;
    logic        send_ready;
    logic [63:0] send_value;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        ack_valid;
    logic        ack_bit;
    logic        seq_bit;
    logic        busy;
    logic        done;
    logic        fail;
    logic [7:0]  retry_count;

    int n_total = 0;
    int n_pass  = 0;

    abp_sender_transmitter #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MR)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .send_valid    (send_valid),
        .send_ready    (send_ready),
        .send_value    (send_value),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .ack_valid     (ack_valid),
        .ack_bit       (ack_bit),
        .seq_bit       (seq_bit),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .retry_count   (retry_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] v, input logic s, input int k);
        logic [63:0] sh;
        if (k == 8) return {7'b0, s};
        sh = v >> (8 * k);
        return sh[7:0];
    endfunction

    // Called at a negedge with aresetn low; returns at the negedge after edge 2.
    task automatic release_reset();
        aresetn = 1'b1;
        @(negedge aclk);
        check("ready_edge1", send_ready, 1'b0);
        @(negedge aclk);
        check("ready_edge2", send_ready, 1'b1);
    endtask

    task automatic handshake(input logic [63:0] v);
        int w = 0;
        while (!send_ready && w < 50) begin
            @(negedge aclk);
            w++;
        end
        check("ready_before_send", send_ready, 1'b1);
        send_valid = 1'b1;
        send_value = v;
        @(negedge aclk);
        send_valid = 1'b0;
        check("ready_drop", send_ready, 1'b0);
        check("busy_send", busy, 1'b1);
    endtask

    // Starts at a negedge where byte 0 is presented; returns at the negedge after the tlast beat.
    task automatic collect(input logic [63:0] v, input logic s, input bit stall);
        int k = 0;
        int cyc = 0;
        bit stalled = 0;
        bit tog = 0;
        logic [7:0] held;
        logic held_last;
        held = '0;
        held_last = 1'b0;
        while (k < 9 && cyc < 200) begin
            if (stalled) check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held_last, held});
            else if (k > 0) check("tvalid_mid_frame", m_axis_tvalid, 1'b1);
            m_axis_tready = stall ? tog : 1'b1;
            tog = !tog;
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("byte%0d", k), m_axis_tdata, exp_byte(v, s, k));
                check($sformatf("tlast%0d", k), m_axis_tlast, (k == 8));
                k++;
                stalled = 0;
            end else if (m_axis_tvalid) begin
                stalled = 1;
                held = m_axis_tdata;
                held_last = m_axis_tlast;
            end
            @(negedge aclk);
            cyc++;
        end
        if (k < 9) check("frame_beats", k, 9);
        m_axis_tready = 1'b1;
        check("tvalid_after_tlast", m_axis_tvalid, 1'b0);
        check("busy_wait_ack", busy, 1'b1);
    endtask

    // Ack sampled on the posedge `delay` cycles after the tlast beat.
    task automatic send_ack(input logic b, input int delay);
        repeat (delay - 1) @(negedge aclk);
        ack_valid = 1'b1;
        ack_bit = b;
        @(negedge aclk);
        ack_valid = 1'b0;
        ack_bit = 1'b0;
    endtask

    task automatic expect_done(input logic s);
        check("done_pulse", done, 1'b1);
        check("seq_toggled", seq_bit, s);
        check("ready_after_done", send_ready, 1'b1);
        check("busy_after_done", busy, 1'b0);
        @(negedge aclk);
        check("done_one_cycle", done, 1'b0);
    endtask

    // From the negedge after a tlast beat to the negedge after the timeout edge.
    task automatic wait_timeout();
        bit early = 0;
        repeat (TO - 1) begin
            @(negedge aclk);
            if (m_axis_tvalid || fail || done) early = 1;
        end
        check("timeout_not_early", early, 1'b0);
        @(negedge aclk);
    endtask

    localparam logic [63:0] V1 = 64'h0807060504030201;
    localparam logic [63:0] V2 = 64'hDEADBEEF00000000;
    localparam logic [63:0] V3 = 64'h1122334455667788;
    localparam logic [63:0] V4 = 64'hCAFEF00D12345678;
    localparam logic [63:0] V5 = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] V6 = 64'hA5A50123456789AB;

    initial begin
        aresetn = 1'b0;
        send_valid = 1'b0;
        send_value = '0;
        m_axis_tready = 1'b1;
        ack_valid = 1'b0;
        ack_bit = 1'b0;
        repeat (2) @(negedge aclk);
        check("reset_outputs",
              {send_ready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, seq_bit, busy, done, fail, retry_count},
              '0);
        release_reset();

        // Basic frame, ack bit 0 five cycles after tlast
        handshake(V1);
        check("first_byte_after_hs", m_axis_tdata, 8'h01);
        collect(V1, 1'b0, 0);
        send_ack(1'b0, 5);
        expect_done(1'b1);

        // Seq byte 01; stale ack bit ignored
        handshake(V2);
        collect(V2, 1'b1, 0);
        send_ack(1'b0, 3);
        check("mismatch_no_done", done, 1'b0);
        check("mismatch_busy", busy, 1'b1);
        check("mismatch_seq", seq_bit, 1'b1);
        send_ack(1'b1, 2);
        expect_done(1'b0);

        // Backpressure every other cycle
        handshake(V3);
        collect(V3, 1'b0, 1);
        send_ack(1'b0, 4);
        expect_done(1'b1);

        // Retry exhaustion: original plus MR retransmissions, then fail
        handshake(V4);
        collect(V4, 1'b1, 0);
        for (int r = 1; r <= int'(MR); r++) begin
            wait_timeout();
            check("retx_tvalid", m_axis_tvalid, 1'b1);
            check("retx_byte0", m_axis_tdata, V4[7:0]);
            check("retx_count", retry_count, 8'(r));
            collect(V4, 1'b1, 0);
        end
        wait_timeout();
        check("fail_pulse", fail, 1'b1);
        check("fail_no_tvalid", m_axis_tvalid, 1'b0);
        check("fail_seq_kept", seq_bit, 1'b1);
        check("fail_ready", send_ready, 1'b1);
        check("fail_not_busy", busy, 1'b0);
        check("fail_no_done", done, 1'b0);
        @(negedge aclk);
        check("fail_one_cycle", fail, 1'b0);

        // Reset while byte 4 is presented
        handshake(V5);
        repeat (4) @(negedge aclk);
        check("byte4_before_reset", m_axis_tdata, V5[39:32]);
        #2 aresetn = 1'b0;
        #1;
        check("async_tvalid_drop", m_axis_tvalid, 1'b0);
        check("async_seq_clear", seq_bit, 1'b0);
        check("async_busy_clear", busy, 1'b0);
        @(negedge aclk);
        release_reset();

        // Fresh frame from byte 0 with seq 00, timeout retransmission, then ack
        handshake(V6);
        collect(V6, 1'b0, 0);
        wait_timeout();
        check("to_retx_tvalid", m_axis_tvalid, 1'b1);
        check("to_retx_byte0", m_axis_tdata, V6[7:0]);
        check("to_retx_count", retry_count, 8'd1);
        check("to_retx_seq", seq_bit, 1'b0);
        collect(V6, 1'b0, 0);
        send_ack(1'b0, 3);
        expect_done(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/abp_sender_transmitter.md
# abp_sender_transmitter

Sender-side packet transmitter for the Alternating Bit Protocol. It accepts a 64-bit value from the sender control logic and serialises it onto an 8-bit AXI-Stream master as a 9-byte frame: 8 value bytes followed by a trailing sequence byte. It then waits for an acknowledge carrying the matching alternating bit, and retransmits the frame on timeout up to a retry limit. It is the transmitting counterpart of the receiver-side packet receiver, and the two share the same frame layout.

## Interface
- TIMEOUT_CYCLES, 1000: cycles spent in WAIT_ACK before retransmitting; legal range 2..65535.
- MAX_RETRIES, 7: number of retransmissions allowed before the frame is abandoned; legal range 0..255.
- aclk  in  1  clock
- aresetn  in  1  asynchronous, active-low reset
- send_valid  in  1  request to send send_value
- send_ready  out  1  block idle and able to accept a request
- send_value  in  64  payload; captured on the send handshake
- m_axis_tvalid  out  1  frame byte valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  final byte of the frame (byte 8)
- m_axis_tdata  out  8  frame byte
- ack_valid  in  1  acknowledge strobe, one cycle
- ack_bit  in  1  alternating bit carried by the acknowledge
- seq_bit  out  1  current alternating bit
- busy  out  1  high in SEND and WAIT_ACK
- done  out  1  one-cycle pulse when the matching ack is accepted
- fail  out  1  one-cycle pulse when retries are exhausted
- retry_count  out  8  retransmissions of the current frame

## Operation
- Frame layout:
  - Bytes 0..7 carry send_value little-endian; byte k = value[8k+7:8k].
  - Byte 8 = {7'b0, seq_bit}, with m_axis_tlast high.
- States: RESET_STATE, IDLE, SEND, WAIT_ACK.
- RESET_STATE: one cycle, then IDLE.
- IDLE:
  - send_ready=1.
  - On send_valid&&send_ready: latch the value, clear idx and retry_count, go to SEND.
- SEND:
  - m_axis_tvalid=1; m_axis_tdata = byte[idx].
  - On an m_axis_tvalid&&m_axis_tready beat: idx+1.
  - A beat with idx==8: go to WAIT_ACK and clear the timer.
- WAIT_ACK:
  - Timer increments every cycle.
  - ack_valid&&ack_bit==seq_bit: toggle seq_bit, pulse done, go to IDLE.
  - ack_valid with a mismatched bit: ignored; the timer is not reset.
  - Timer==TIMEOUT_CYCLES-1 with no matching ack:
    - If retry_count<MAX_RETRIES: retry_count+1, idx=0, go to SEND (retransmit the identical frame, same seq_bit).
    - Otherwise: pulse fail, go to IDLE, seq_bit unchanged.
- A matching ack and the timeout in the same cycle: the ack wins.
- ack_valid outside WAIT_ACK is ignored.
- idx is 4 bits; the timer is 16 bits; retry_count never wraps because it is capped by MAX_RETRIES.

## Timing
- All outputs are registered.
- Reset values: 0 for send_ready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, seq_bit, busy, done, fail and retry_count.
- send_ready rises on the second aclk edge after aresetn deasserts.
- Handshake at edge N: m_axis_tvalid=1 with byte 0 from N+1.
- With m_axis_tready held high, bytes 0..8 appear at N+1..N+9, with tlast at N+9.
- While m_axis_tvalid=1 and m_axis_tready=0: tdata and tlast hold; tvalid never drops mid-frame.
- A matching ack sampled at edge M: done=1, send_ready=1 and seq_bit toggled are all visible after M.
- Timeout: the first retransmitted byte 0 is valid exactly TIMEOUT_CYCLES cycles after the tlast beat.
- Reset mid-frame: tvalid drops asynchronously, the frame is abandoned, and seq_bit returns to 0.

## Structure
- Shared package abp_pkg holds:
  - ABP_VALUE_BYTES=8.
  - ABP_FRAME_BYTES=9.
  - ABP_SEQ_BYTE_IDX=8.
  - The sender transmitter state enum typedef.
- The receiver uses the same package constants.
- Sub-module abp_retry_timer:
  - Load/clear input, enable input, expired output.
  - Parameterised by TIMEOUT_CYCLES.

## Test plan
- Send 64'h0807060504030201 with tready=1 and ack(bit 0) 5 cycles after tlast -> bytes 01..08 then 00, tlast on byte 8, done pulse, seq_bit=1.
- Second send 64'hDEADBEEF00000000 -> seq byte 01. ack_bit=0 is ignored; ack_bit=1 -> done, seq_bit=0.
- Toggle tready every other cycle -> data stable while stalled, 9 beats, tlast only on the last beat.
- No ack with TIMEOUT_CYCLES=20 -> identical frame resent 20 cycles after tlast, retry_count=1. A subsequent ack -> done.
- MAX_RETRIES=2 with no ack -> 3 frames, then fail pulse, seq_bit unchanged, send_ready=1.
- aresetn low during byte 4 -> tvalid=0 immediately. After release, the next send starts at byte 0 with seq 00.
